easyaxi_mst_wr: RTL and testbench
=================================

// Module: easyaxi_mst_wr
// PURPOSE
//  AXI4 write-burst master traffic generator inside EASYAXI_TOP, first stage behind the top-level enable/done pins.
//  On enable it issues TXN_NUM INCR write bursts of BURST_LEN beats on the AW/W channels and collects every B response.
//  It then raises done and holds it until enable drops. Downstream consumer: the AXI slave/interconnect.
// PARAMETERS
//  ADDR_WIDTH  16      AXI address width
//  DATA_WIDTH  32      AXI data width (power of 2, 8..128)
//  ID_WIDTH    4       AWID/BID width
//  BURST_LEN   4       beats per burst (1..16); AWLEN = BURST_LEN-1
//  TXN_NUM     4       bursts per run (1..2^ID_WIDTH)
//  BASE_ADDR   16'h0   byte address of first beat, DATA_WIDTH/8 aligned
// PORTS
//  clk      in   1           clock, rising edge
//  rst      in   1           async active-high reset
//  enable   in   1           start request (level)
//  done     out  1           all bursts complete, held while enable=1
//  err      out  1           sticky: some BRESP != OKAY or BID mismatch
//  awid     out  ID_WIDTH    burst index, truncated
//  awaddr   out  ADDR_WIDTH  burst start address
//  awlen    out  8           BURST_LEN-1
//  awsize   out  3           log2(DATA_WIDTH/8)
//  awburst  out  2           2'b01 (INCR)
//  awvalid  out  1           AW valid
//  awready  in   1           AW ready
//  wdata    out  DATA_WIDTH  beat byte address, zero-extended
//  wstrb    out  DATA_WIDTH/8 all ones
//  wlast    out  1           final beat of burst
//  wvalid   out  1           W valid
//  wready   in   1           W ready
//  bid      in   ID_WIDTH    response ID
//  bresp    in   2           response code
//  bvalid   in   1           B valid
//  bready   out  1           B ready
// BEHAVIOUR
//  Reset: state IDLE; done, err, awvalid, wvalid, wlast, bready = 0; txn/beat counters = 0. Reset is honoured at any time, mid-burst included; the slave is expected to be reset alongside.
//  FSM: IDLE -> AW -> W -> B -> (AW | DONE) -> IDLE.
//   IDLE: enable=1 -> AW, clearing txn_cnt and err. Takes 1 cycle to reach AW.
//   AW: awvalid=1; awid, awaddr, awlen stable until awready. Handshake -> W, beat_cnt=0.
//   W: wvalid=1; each wready advances beat_cnt. wlast=1 iff beat_cnt==BURST_LEN-1. Last handshake -> B.
//   B: bready=1. On bvalid, set err if bresp!=2'b00 or bid!=awid. If txn_cnt==TXN_NUM-1 -> DONE, else txn_cnt++ and -> AW.
//   DONE: done=1; enable=0 -> IDLE (done drops next cycle). err holds until the next start.
//  AW and W never overlap: wvalid stays 0 until the AW handshake completes. One outstanding burst at a time.
//  Valid never deasserts before its ready. Payload never changes while valid=1 and ready=0.
//  awaddr = BASE_ADDR + txn_cnt*BURST_LEN*(DATA_WIDTH/8), mod 2^ADDR_WIDTH (wraps silently).
//  wdata = awaddr + beat_cnt*(DATA_WIDTH/8).
//  enable dropping mid-run is ignored; the run always completes to DONE. DONE then exits at once if enable=0.
//  bvalid outside B state is ignored, and bready=0 there.
//  Minimum burst time with ready tied high: 1 (AW) + BURST_LEN (W) + 1 (B) cycles.
// TESTING
//  T1 defaults, ready=1, bvalid one cycle after wlast -> 4 bursts at 0x00/0x10/0x20/0x30, data 0x0..0x3C, done rises, err=0.
//  T2 awready delayed 3 cycles, random wready stalls -> awaddr/wdata/wlast stable under stall, 16 beats total, done=1.
//  T3 bresp=2'b10 on burst 2 only -> err=1 at done. Restarting enable clears err; a clean run ends with err=0.
//  T4 rst=1 during beat 2 of burst 1 -> all outputs 0 immediately (async). Next enable restarts at awaddr=0x00.
//  T5 enable dropped during burst 0 -> all 4 bursts still issued, done pulses 1 cycle, return to IDLE.
//  T6 BASE_ADDR=16'hFFF0 -> burst 1 awaddr wraps to 0x0000, no X, done=1.

Source files
------------

// File: rtl/easyaxi_mst_wr.sv
// AXI4 write-burst traffic generator: issues TXN_NUM INCR bursts of BURST_LEN beats on AW/W,
// collects each B response, then holds done until enable drops. One burst outstanding at a time.
module easyaxi_mst_wr #(
  parameter int unsigned          ADDR_WIDTH = 16,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ID_WIDTH   = 4,
  parameter int unsigned          BURST_LEN  = 4,
  parameter int unsigned          TXN_NUM    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  output logic                    done_o,
  output logic                    err_o,
  output logic [ID_WIDTH-1:0]     awid_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic [7:0]              awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wlast_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [ID_WIDTH-1:0]     bid_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o
);

  localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned BEAT_W      = $clog2(BURST_LEN + 1);
  localparam int unsigned TXN_W       = $clog2(TXN_NUM + 1);
  localparam int unsigned BURST_BYTES = BURST_LEN * STRB_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [TXN_W-1:0]        txn_q, txn_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ID_WIDTH-1:0]     awid_q, awid_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic                    wlast_q, wlast_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    done_q, done_d;
  logic                    last_beat, last_txn;

  assign last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign last_txn  = (txn_q == TXN_W'(TXN_NUM - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable_i) state_d = S_AW;
      S_AW:   if (awready_i) state_d = S_W;
      S_W:    if (wready_i && last_beat) state_d = S_B;
      S_B:    if (bvalid_i) state_d = last_txn ? S_DONE : S_AW;
      S_DONE: if (!enable_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters and next-cycle outputs; payload is a pure function of the counters, so it holds under stall.
  always_comb begin
    txn_d  = txn_q;
    beat_d = beat_q;
    err_d  = err_q;
    case (state_q)
      S_IDLE: if (enable_i) begin
        txn_d = '0;
        err_d = 1'b0;
      end
      S_AW: if (awready_i) beat_d = '0;
      S_W:  if (wready_i) beat_d = beat_q + BEAT_W'(1);
      S_B:  if (bvalid_i) begin
        if (bresp_i != 2'b00 || bid_i != awid_q) err_d = 1'b1;
        if (!last_txn) txn_d = txn_q + TXN_W'(1);
      end
      default: ;
    endcase
    awaddr_d  = BASE_ADDR + ADDR_WIDTH'(txn_d) * ADDR_WIDTH'(BURST_BYTES);
    beat_addr = awaddr_d + ADDR_WIDTH'(beat_d) * ADDR_WIDTH'(STRB_WIDTH);
    wdata_d   = DATA_WIDTH'(beat_addr);
    awid_d    = ID_WIDTH'(txn_d);
    awvalid_d = (state_d == S_AW);
    wvalid_d  = (state_d == S_W);
    wlast_d   = (state_d == S_W) && (beat_d == BEAT_W'(BURST_LEN - 1));
    bready_d  = (state_d == S_B);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      txn_q     <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      awaddr_q  <= '0;
      awid_q    <= '0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      txn_q     <= txn_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      awaddr_q  <= awaddr_d;
      awid_q    <= awid_d;
      wdata_q   <= wdata_d;
      wlast_q   <= wlast_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
    end
  end

  assign done_o    = done_q;
  assign err_o     = err_q;
  assign awid_o    = awid_q;
  assign awaddr_o  = awaddr_q;
  assign awlen_o   = 8'(BURST_LEN - 1);
  assign awsize_o  = 3'($clog2(STRB_WIDTH));
  assign awburst_o = 2'b01;
  assign awvalid_o = awvalid_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = '1;
  assign wlast_o   = wlast_q;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;

endmodule

// File: tb/tb_easyaxi_mst_wr.sv
// Scoreboard bench for easyaxi_mst_wr: a slave/monitor loop pops expected AW/W payloads on each handshake.
module tb_easyaxi_mst_wr;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned BL = 4;
  localparam int unsigned TN = 4;

  logic clk;
  logic rst;
  logic en1, en2, sel;
  logic awready, wready, bvalid;
  logic [IW-1:0] bid;
  logic [1:0] bresp;

  logic d1_done, d1_err, d1_awvalid, d1_wlast, d1_wvalid, d1_bready;
  logic [IW-1:0] d1_awid;
  logic [AW-1:0] d1_awaddr;
  logic [7:0] d1_awlen;
  logic [2:0] d1_awsize;
  logic [1:0] d1_awburst;
  logic [DW-1:0] d1_wdata;
  logic [DW/8-1:0] d1_wstrb;

  logic d2_done, d2_err, d2_awvalid, d2_wlast, d2_wvalid, d2_bready;
  logic [IW-1:0] d2_awid;
  logic [AW-1:0] d2_awaddr;
  logic [7:0] d2_awlen;
  logic [2:0] d2_awsize;
  logic [1:0] d2_awburst;
  logic [DW-1:0] d2_wdata;
  logic [DW/8-1:0] d2_wstrb;

  logic m_done, m_err, m_awvalid, m_wlast, m_wvalid, m_bready;
  logic [IW-1:0] m_awid;
  logic [AW-1:0] m_awaddr;
  logic [7:0] m_awlen;
  logic [2:0] m_awsize;
  logic [1:0] m_awburst;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;

  easyaxi_mst_wr dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .done_o(d1_done), .err_o(d1_err),
    .awid_o(d1_awid), .awaddr_o(d1_awaddr), .awlen_o(d1_awlen), .awsize_o(d1_awsize),
    .awburst_o(d1_awburst), .awvalid_o(d1_awvalid), .awready_i(awready),
    .wdata_o(d1_wdata), .wstrb_o(d1_wstrb), .wlast_o(d1_wlast), .wvalid_o(d1_wvalid),
    .wready_i(wready), .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(d1_bready)
  );

  easyaxi_mst_wr #(.BASE_ADDR(16'hFFF0)) dut2 (
    .clk_i(clk), .rst_i(rst), .enable_i(en2), .done_o(d2_done), .err_o(d2_err),
    .awid_o(d2_awid), .awaddr_o(d2_awaddr), .awlen_o(d2_awlen), .awsize_o(d2_awsize),
    .awburst_o(d2_awburst), .awvalid_o(d2_awvalid), .awready_i(awready),
    .wdata_o(d2_wdata), .wstrb_o(d2_wstrb), .wlast_o(d2_wlast), .wvalid_o(d2_wvalid),
    .wready_i(wready), .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(d2_bready)
  );

  // The idle instance ignores the shared slave inputs, so one slave model serves both.
  assign m_done    = sel ? d2_done    : d1_done;
  assign m_err     = sel ? d2_err     : d1_err;
  assign m_awid    = sel ? d2_awid    : d1_awid;
  assign m_awaddr  = sel ? d2_awaddr  : d1_awaddr;
  assign m_awlen   = sel ? d2_awlen   : d1_awlen;
  assign m_awsize  = sel ? d2_awsize  : d1_awsize;
  assign m_awburst = sel ? d2_awburst : d1_awburst;
  assign m_awvalid = sel ? d2_awvalid : d1_awvalid;
  assign m_wdata   = sel ? d2_wdata   : d1_wdata;
  assign m_wstrb   = sel ? d2_wstrb   : d1_wstrb;
  assign m_wlast   = sel ? d2_wlast   : d1_wlast;
  assign m_wvalid  = sel ? d2_wvalid  : d1_wvalid;
  assign m_bready  = sel ? d2_bready  : d1_bready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int aw_delay = 0;
  bit wstall = 1'b0;
  int berr_burst = -1;
  int w_seen = 0;

  logic [15:0] exp_aw_addr[$];
  logic [3:0]  exp_aw_id[$];
  logic [31:0] exp_w_data[$];
  logic        exp_w_last[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_run(input logic [15:0] base);
    logic [15:0] a;
    for (int t = 0; t < int'(TN); t++) begin
      a = base + 16'(t * 16);
      exp_aw_addr.push_back(a);
      exp_aw_id.push_back(4'(t));
      for (int b = 0; b < int'(BL); b++) begin
        exp_w_data.push_back(32'(16'(a + 16'(b * 4))));
        exp_w_last.push_back(b == int'(BL) - 1);
      end
    end
  endtask

  // Slave drives at posedge+1; monitor checks handshakes at negedge, mid-cycle.
  initial begin : slave_mon
    int aw_cnt;
    bit pend_b, b_hs, aw_hold, w_hold;
    logic [3:0] cur_id, sv_awid;
    logic [15:0] sv_awaddr, ea;
    logic [31:0] sv_wdata, ed;
    logic sv_wlast, el;
    aw_cnt = 0; pend_b = 0; b_hs = 0; aw_hold = 0; w_hold = 0; cur_id = '0;
    sv_awid = '0; sv_awaddr = '0; sv_wdata = '0; sv_wlast = 0;
    awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; aw_cnt = 0;
        pend_b = 0; b_hs = 0; aw_hold = 0; w_hold = 0;
      end else begin
        if (m_awvalid) begin
          awready = (aw_cnt >= aw_delay);
          aw_cnt++;
        end else begin
          awready = 0;
          aw_cnt = 0;
        end
        wready = wstall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (b_hs) begin
          bvalid = 0;
          b_hs = 0;
        end else if (pend_b && !bvalid) begin
          bvalid = 1;
          bid = cur_id;
          bresp = (int'(cur_id) == berr_burst) ? 2'b10 : 2'b00;
          pend_b = 0;
        end
      end
      @(negedge clk);
      if (!rst) begin
        chk("aw_w_overlap", 32'(m_awvalid & m_wvalid), 0);
        if (aw_hold) begin
          chk("aw_stall_valid", 32'(m_awvalid), 1);
          chk("aw_stall_addr", 32'(m_awaddr), 32'(sv_awaddr));
          chk("aw_stall_id", 32'(m_awid), 32'(sv_awid));
        end
        if (w_hold) begin
          chk("w_stall_valid", 32'(m_wvalid), 1);
          chk("w_stall_data", m_wdata, sv_wdata);
          chk("w_stall_last", 32'(m_wlast), 32'(sv_wlast));
        end
        if (m_awvalid && awready) begin
          if (exp_aw_addr.size() == 0) begin
            chk("aw_unexpected", 32'(m_awaddr), 32'hFFFF_FFFF);
          end else begin
            ea = exp_aw_addr.pop_front();
            chk("awaddr", 32'(m_awaddr), 32'(ea));
            chk("awid", 32'(m_awid), 32'(exp_aw_id.pop_front()));
            chk("awlen", 32'(m_awlen), 32'd3);
            chk("awsize", 32'(m_awsize), 32'd2);
            chk("awburst", 32'(m_awburst), 32'd1);
          end
          cur_id = m_awid;
        end
        aw_hold = m_awvalid && !awready;
        sv_awaddr = m_awaddr;
        sv_awid = m_awid;
        if (m_wvalid && wready) begin
          if (exp_w_data.size() == 0) begin
            chk("w_unexpected", m_wdata, 32'hFFFF_FFFF);
          end else begin
            ed = exp_w_data.pop_front();
            el = exp_w_last.pop_front();
            chk("wdata", m_wdata, ed);
            chk("wlast", 32'(m_wlast), 32'(el));
            chk("wstrb", 32'(m_wstrb), 32'hF);
          end
          w_seen++;
          if (m_wlast) pend_b = 1;
        end
        w_hold = m_wvalid && !wready;
        sv_wdata = m_wdata;
        sv_wlast = m_wlast;
        if (bvalid && m_bready) b_hs = 1;
      end
    end
  end

  task automatic start(input logic [15:0] base);
    push_run(base);
    @(posedge clk);
    #1;
    if (sel) en2 = 1'b1;
    else     en1 = 1'b1;
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    while (!m_done && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk(name, 32'(m_done), 1);
  endtask

  task automatic finish_run(input string name);
    en1 = 1'b0;
    en2 = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_done_drop"}, 32'(m_done), 0);
    chk({name, "_aw_q_empty"}, 32'(exp_aw_addr.size()), 0);
    chk({name, "_w_q_empty"}, 32'(exp_w_data.size()), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int cyc, w0, k;
    rst = 1'b1; en1 = 1'b0; en2 = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_done", 32'(m_done), 0);
    chk("rst_err", 32'(m_err), 0);
    chk("rst_awvalid", 32'(m_awvalid), 0);
    chk("rst_wvalid", 32'(m_wvalid), 0);
    chk("rst_wlast", 32'(m_wlast), 0);
    chk("rst_bready", 32'(m_bready), 0);

    // T1: ready tied high; 4 bursts of 6 cycles plus 1 cycle IDLE->AW.
    start(16'h0000);
    wait_done("t1_done", cyc);
    chk("t1_cycles", 32'(cyc), 25);
    chk("t1_err", 32'(m_err), 0);
    finish_run("t1");

    // T2: awready delayed, random wready stalls.
    aw_delay = 3; wstall = 1'b1;
    w0 = w_seen;
    start(16'h0000);
    wait_done("t2_done", cyc);
    chk("t2_beats", 32'(w_seen - w0), 16);
    chk("t2_err", 32'(m_err), 0);
    finish_run("t2");
    aw_delay = 0; wstall = 1'b0;

    // T3: SLVERR on burst 2, err sticky until restart.
    berr_burst = 2;
    start(16'h0000);
    wait_done("t3_done", cyc);
    chk("t3_err_set", 32'(m_err), 1);
    finish_run("t3");
    chk("t3_err_hold", 32'(m_err), 1);
    berr_burst = -1;
    start(16'h0000);
    @(posedge clk);
    #1;
    chk("t3_err_clear", 32'(m_err), 0);
    wait_done("t3b_done", cyc);
    chk("t3b_err", 32'(m_err), 0);
    finish_run("t3b");

    // T4: async reset while beat 2 of burst 1 is on the bus.
    w0 = w_seen;
    start(16'h0000);
    k = 0;
    while ((w_seen - w0) < 6 && k < 500) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("t4_reach_beat", 32'(w_seen - w0), 6);
    rst = 1'b1;
    en1 = 1'b0;
    #1;
    chk("t4_awvalid", 32'(m_awvalid), 0);
    chk("t4_wvalid", 32'(m_wvalid), 0);
    chk("t4_wlast", 32'(m_wlast), 0);
    chk("t4_bready", 32'(m_bready), 0);
    chk("t4_done", 32'(m_done), 0);
    chk("t4_err", 32'(m_err), 0);
    chk("t4_awaddr", 32'(m_awaddr), 0);
    chk("t4_wdata", m_wdata, 0);
    exp_aw_addr.delete(); exp_aw_id.delete();
    exp_w_data.delete(); exp_w_last.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start(16'h0000);
    wait_done("t4_done_after", cyc);
    chk("t4_err_after", 32'(m_err), 0);
    finish_run("t4");

    // T5: enable dropped during burst 0; run completes, done pulses once.
    start(16'h0000);
    @(posedge clk);
    #1;
    en1 = 1'b0;
    wait_done("t5_done", cyc);
    @(posedge clk);
    #1;
    chk("t5_done_pulse", 32'(m_done), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_idle_awvalid", 32'(m_awvalid), 0);
    chk("t5_aw_q_empty", 32'(exp_aw_addr.size()), 0);
    chk("t5_w_q_empty", 32'(exp_w_data.size()), 0);

    // T6: base 0xFFF0, second burst wraps to 0x0000.
    sel = 1'b1;
    start(16'hFFF0);
    wait_done("t6_done", cyc);
    chk("t6_err", 32'(m_err), 0);
    finish_run("t6");
    sel = 1'b0;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
